// File: rtl/core_gbus_arb_pkg.sv
// Shared widths, beat record and output-register state encoding for the per-head
// gbus write collector.
package core_gbus_arb_pkg;

    localparam int BUS_CMEM_ADDR_WIDTH  = 13;
    localparam int BUS_CORE_ADDR_WIDTH  = 4;
    localparam int HEAD_SRAM_BIAS_WIDTH = 2;
    localparam int GBUS_ADDR_WIDTH      = HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH
                                          + BUS_CMEM_ADDR_WIDTH;
    localparam int GBUS_DATA_WIDTH      = 128;

    typedef struct packed {
        logic [GBUS_ADDR_WIDTH-1:0] addr;
        logic [GBUS_DATA_WIDTH-1:0] data;
    } gbus_beat_t;

    localparam int GBUS_BEAT_WIDTH = $bits(gbus_beat_t);

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/gbus_arb_fifo.sv
// Per-core write FIFO: registered storage, show-ahead read port, and a push that is
// still accepted when full provided the same cycle pops. Caller pops only when non-empty.
module gbus_arb_fifo
    import core_gbus_arb_pkg::*;
#(
    parameter int WIDTH = GBUS_BEAT_WIDTH,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    // When full, the slot being written is the one being read out this cycle.
    assign push_ok  = push && (!full || pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/core_gbus_arb.sv
// Collects fire-and-forget core gbus writes into per-core FIFOs and drives one
// round-robin arbitrated head channel. Optional perf counters: CORE_GBUS_ARB_PERF_EN.
// Handshake: a beat transfers on a rising edge where head_gbus_wen && head_gbus_rdy;
// while wen=1 and rdy=0 the beat (addr/wdata/src) is held unchanged.
module core_gbus_arb #(
    parameter int CORE_NUM        = 8,
    parameter int GBUS_DATA_WIDTH = core_gbus_arb_pkg::GBUS_DATA_WIDTH,
    parameter int GBUS_ADDR_WIDTH = core_gbus_arb_pkg::GBUS_ADDR_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    localparam int SRC_W = $clog2(CORE_NUM)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [CORE_NUM-1:0]                 core_gbus_wen,
    input  logic [CORE_NUM*GBUS_ADDR_WIDTH-1:0] core_gbus_addr,
    input  logic [CORE_NUM*GBUS_DATA_WIDTH-1:0] core_gbus_wdata,
    output logic                                head_gbus_wen,
    output logic [GBUS_ADDR_WIDTH-1:0]          head_gbus_addr,
    output logic [GBUS_DATA_WIDTH-1:0]          head_gbus_wdata,
    output logic [SRC_W-1:0]                    head_gbus_src,
    input  logic                                head_gbus_rdy,
    input  logic                                ovf_clr,
    output logic [CORE_NUM-1:0]                 ovf_flag,
    output logic                                busy
`ifdef CORE_GBUS_ARB_PERF_EN
    ,
    input  logic                                perf_clr,
    output logic [31:0]                         perf_stall_cnt,
    output logic [31:0]                         perf_beat_cnt
`endif
);

    import core_gbus_arb_pkg::*;

    localparam int BEAT_W = GBUS_ADDR_WIDTH + GBUS_DATA_WIDTH;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    logic [BEAT_W-1:0]          fifo_dout [CORE_NUM];
    logic [CNT_W-1:0]           fifo_count [CORE_NUM];
    logic [CORE_NUM-1:0]        fifo_full, fifo_empty, fifo_pop, fifo_req;

    out_state_t                 state_q, state_d;
    logic [SRC_W-1:0]           ptr_q, ptr_d;
    logic [SRC_W-1:0]           src_q, src_d;
    logic [GBUS_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [GBUS_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CORE_NUM-1:0]        ovf_q, ovf_d;

    logic                       grant_vld, load, any_pending;
    logic [SRC_W-1:0]           grant_idx;
    gbus_beat_t                 grant_beat;

    for (genvar i = 0; i < CORE_NUM; i++) begin : g_fifo
        gbus_arb_fifo #(
            .WIDTH (BEAT_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (core_gbus_wen[i]),
            .push_data ({core_gbus_addr[i*GBUS_ADDR_WIDTH +: GBUS_ADDR_WIDTH],
                         core_gbus_wdata[i*GBUS_DATA_WIDTH +: GBUS_DATA_WIDTH]}),
            .pop       (fifo_pop[i]),
            .pop_data  (fifo_dout[i]),
            .full      (fifo_full[i]),
            .empty     (fifo_empty[i]),
            .count     (fifo_count[i])
        );
        assign fifo_req[i] = !fifo_empty[i];
        assign fifo_pop[i] = load && (grant_idx == SRC_W'(i));
    end

    // Round-robin: first requester at or after ptr_q, wrapping at CORE_NUM-1.
    always_comb begin
        int cand;
        logic [SRC_W-1:0] cand_idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 0; k < CORE_NUM; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= CORE_NUM) begin
                cand = cand - CORE_NUM;
            end
            cand_idx = SRC_W'(cand);
            if (!grant_vld && fifo_req[cand_idx]) begin
                grant_vld = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    assign grant_beat = gbus_beat_t'(fifo_dout[grant_idx]);
    assign load       = grant_vld && ((state_q == OUT_EMPTY) || head_gbus_rdy);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = OUT_FULL;
        end else if ((state_q == OUT_FULL) && head_gbus_rdy) begin
            state_d = OUT_EMPTY;
        end
    end

    always_comb begin
        head_gbus_wen = (state_q == OUT_FULL);
    end

    always_comb begin
        ptr_d   = ptr_q;
        src_d   = src_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (load) begin
            src_d   = grant_idx;
            addr_d  = grant_beat.addr;
            wdata_d = grant_beat.data;
            ptr_d   = (grant_idx == SRC_W'(CORE_NUM - 1)) ? '0 : grant_idx + SRC_W'(1);
        end
        // A fresh drop outranks a clear in the same cycle.
        ovf_d = (ovf_q & ~{CORE_NUM{ovf_clr}}) | (core_gbus_wen & fifo_full & ~fifo_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ovf_q   <= '0;
        end else begin
            ptr_q   <= ptr_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < CORE_NUM; i++) begin
            if (fifo_count[i] != '0) begin
                any_pending = 1'b1;
            end
        end
    end

    assign busy            = any_pending || head_gbus_wen;
    assign head_gbus_src   = src_q;
    assign head_gbus_addr  = addr_q;
    assign head_gbus_wdata = wdata_q;
    assign ovf_flag        = ovf_q;

`ifdef CORE_GBUS_ARB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        beat_cnt_d  = beat_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            beat_cnt_d  = '0;
        end else begin
            if (head_gbus_wen && !head_gbus_rdy && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
            if (head_gbus_wen && head_gbus_rdy && (beat_cnt_q != '1)) begin
                beat_cnt_d = beat_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            beat_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_beat_cnt  = beat_cnt_q;
`endif

endmodule

// File: tb/tb_core_gbus_arb.sv
// Directed bench for core_gbus_arb: single-write vector table plus hand sequences for
// bursts, backpressure, overflow, full-with-pop and asynchronous reset.
module tb_core_gbus_arb;

    localparam int N  = 8;
    localparam int AW = 19;
    localparam int DW = 128;
    localparam int SW = 3;
    localparam int SB = SW + AW + DW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    core_gbus_wen = '0;
    logic [N*AW-1:0] core_gbus_addr = '0;
    logic [N*DW-1:0] core_gbus_wdata = '0;
    logic            head_gbus_wen;
    logic [AW-1:0]   head_gbus_addr;
    logic [DW-1:0]   head_gbus_wdata;
    logic [SW-1:0]   head_gbus_src;
    logic            head_gbus_rdy = 1'b1;
    logic            ovf_clr = 1'b0;
    logic [N-1:0]    ovf_flag;
    logic            busy;
`ifdef CORE_GBUS_ARB_PERF_EN
    logic            perf_clr = 1'b0;
    logic [31:0]     perf_stall_cnt;
    logic [31:0]     perf_beat_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [SB-1:0] exp_q[$];

    typedef struct {
        int            core;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] exp_src;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t vecs[4];

    core_gbus_arb #(
        .CORE_NUM        (N),
        .GBUS_DATA_WIDTH (DW),
        .GBUS_ADDR_WIDTH (AW),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .core_gbus_wen   (core_gbus_wen),
        .core_gbus_addr  (core_gbus_addr),
        .core_gbus_wdata (core_gbus_wdata),
        .head_gbus_wen   (head_gbus_wen),
        .head_gbus_addr  (head_gbus_addr),
        .head_gbus_wdata (head_gbus_wdata),
        .head_gbus_src   (head_gbus_src),
        .head_gbus_rdy   (head_gbus_rdy),
        .ovf_clr         (ovf_clr),
        .ovf_flag        (ovf_flag),
        .busy            (busy)
`ifdef CORE_GBUS_ARB_PERF_EN
        ,
        .perf_clr        (perf_clr),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_beat_cnt   (perf_beat_cnt)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic set_write(input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        core_gbus_wen[c] = 1'b1;
        core_gbus_addr[c*AW +: AW] = a;
        core_gbus_wdata[c*DW +: DW] = d;
    endtask

    task automatic clear_writes();
        core_gbus_wen = '0;
    endtask

    function automatic logic [AW-1:0] mk_addr(input int c, input int k);
        return AW'(c * 4096 + k * 16 + 1);
    endfunction

    function automatic logic [DW-1:0] mk_data(input int c, input int k);
        return {32'hC0DE_0000 + 32'(c), 32'(k), 32'h5A5A_0000 + 32'(c * 16 + k), ~32'(k)};
    endfunction

    // Scoreboard
    task automatic compare_head(input string name);
        logic [SB-1:0] e;
        if (exp_q.size() == 0) begin
            chk({name, " unexpected"}, 256'(head_gbus_wen), 256'(0));
            return;
        end
        e = exp_q.pop_front();
        chk(name, 256'({head_gbus_wen, head_gbus_src, head_gbus_addr, head_gbus_wdata}),
            256'({1'b1, e}));
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        head_gbus_rdy = 1'b1;
        while (exp_q.size() != 0 && n < budget) begin
            if (head_gbus_wen) compare_head(name);
            tick();
            n++;
        end
        chk({name, " leftover"}, 256'(exp_q.size()), 256'(0));
        chk({name, " no extra beat"}, 256'(head_gbus_wen), 256'(0));
    endtask

    initial begin
        logic [SB-1:0] held;
        int seen;

        vecs[0] = '{core: 3, addr: 19'h00123, data: {16{8'hA5}}, exp_src: 3'd3,
                    exp_addr: 19'h00123, exp_data: {16{8'hA5}}};
        vecs[1] = '{core: 0, addr: 19'h7FFFF, data: {4{32'hDEAD_BEEF}}, exp_src: 3'd0,
                    exp_addr: 19'h7FFFF, exp_data: {4{32'hDEAD_BEEF}}};
        vecs[2] = '{core: 5, addr: 19'h40000, data: 128'h1, exp_src: 3'd5,
                    exp_addr: 19'h40000, exp_data: 128'h1};
        vecs[3] = '{core: 7, addr: 19'h00000, data: {128{1'b1}}, exp_src: 3'd7,
                    exp_addr: 19'h00000, exp_data: {128{1'b1}}};

        // Reset state
        repeat (2) tick();
        chk("reset wen", 256'(head_gbus_wen), 256'(0));
        chk("reset addr", 256'(head_gbus_addr), 256'(0));
        chk("reset wdata", 256'(head_gbus_wdata), 256'(0));
        chk("reset src", 256'(head_gbus_src), 256'(0));
        chk("reset ovf", 256'(ovf_flag), 256'(0));
        chk("reset busy", 256'(busy), 256'(0));
        rst = 1'b0;
        tick();

        // Single writes: two-cycle latency, exactly one beat, then idle
        for (int i = 0; i < 4; i++) begin
            set_write(vecs[i].core, vecs[i].addr, vecs[i].data);
            tick();
            clear_writes();
            chk("t1 wen after push", 256'(head_gbus_wen), 256'(0));
            chk("t1 busy after push", 256'(busy), 256'(1));
            tick();
            chk("t1 wen", 256'(head_gbus_wen), 256'(1));
            chk("t1 src", 256'(head_gbus_src), 256'(vecs[i].exp_src));
            chk("t1 addr", 256'(head_gbus_addr), 256'(vecs[i].exp_addr));
            chk("t1 data", 256'(head_gbus_wdata), 256'(vecs[i].exp_data));
            tick();
            chk("t1 wen idle", 256'(head_gbus_wen), 256'(0));
            chk("t1 busy idle", 256'(busy), 256'(0));
        end

        // All cores at once, twice: 0..7 back to back each time
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < N; c++) begin
                set_write(c, mk_addr(c, b), mk_data(c, b));
                exp_q.push_back({SW'(c), mk_addr(c, b), mk_data(c, b)});
            end
            tick();
            clear_writes();
            tick();
            for (int i = 0; i < N; i++) begin
                compare_head("t2 burst beat");
                tick();
            end
            chk("t2 idle after burst", 256'(head_gbus_wen), 256'(0));
        end

`ifdef CORE_GBUS_ARB_PERF_EN
        chk("perf beats before clr", 256'(perf_beat_cnt), 256'(16 + 4));
        perf_clr = 1'b1;
        tick();
        perf_clr = 1'b0;
        chk("perf stall clr", 256'(perf_stall_cnt), 256'(0));
        chk("perf beat clr", 256'(perf_beat_cnt), 256'(0));
`endif

        // Backpressure: beat held for 5 stalled cycles, then two beats back to back
        head_gbus_rdy = 1'b0;
        set_write(1, mk_addr(1, 10), mk_data(1, 10));
        set_write(2, mk_addr(2, 10), mk_data(2, 10));
        tick();
        clear_writes();
        tick();
        held = {3'd1, mk_addr(1, 10), mk_data(1, 10)};
        chk("t3 first beat", 256'({head_gbus_wen, head_gbus_src, head_gbus_addr, head_gbus_wdata}),
            256'({1'b1, held}));
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("t3 held", 256'({head_gbus_wen, head_gbus_src, head_gbus_addr, head_gbus_wdata}),
                256'({1'b1, held}));
        end
        head_gbus_rdy = 1'b1;
        tick();
        chk("t3 next beat", 256'({head_gbus_wen, head_gbus_src, head_gbus_addr, head_gbus_wdata}),
            256'({1'b1, 3'd2, mk_addr(2, 10), mk_data(2, 10)}));
        tick();
        chk("t3 idle", 256'(head_gbus_wen), 256'(0));
`ifdef CORE_GBUS_ARB_PERF_EN
        chk("t3 perf stalls", 256'(perf_stall_cnt), 256'(5));
        chk("t3 perf beats", 256'(perf_beat_cnt), 256'(2));
`endif

        // Overflow: output register occupied by core 4, core 5 writes 6 times
        head_gbus_rdy = 1'b0;
        set_write(4, mk_addr(4, 0), mk_data(4, 0));
        exp_q.push_back({3'd4, mk_addr(4, 0), mk_data(4, 0)});
        tick();
        clear_writes();
        tick();
        for (int k = 0; k < 6; k++) begin
            set_write(5, mk_addr(5, k), mk_data(5, k));
            if (k < 4) exp_q.push_back({3'd5, mk_addr(5, k), mk_data(5, k)});
            ovf_clr = (k == 5);
            tick();
            clear_writes();
            ovf_clr = 1'b0;
            if (k == 3) chk("t4 ovf before drop", 256'(ovf_flag), 256'(0));
            if (k == 4) chk("t4 ovf on drop", 256'(ovf_flag), 256'(8'h20));
            if (k == 5) chk("t4 ovf set beats clr", 256'(ovf_flag), 256'(8'h20));
        end
        drain("t4 beat", 30);
        chk("t4 ovf sticky", 256'(ovf_flag), 256'(8'h20));
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4 ovf cleared", 256'(ovf_flag), 256'(0));

        // Push into a full FIFO on the cycle it pops
        head_gbus_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_write(0, mk_addr(0, 20 + k), mk_data(0, 20 + k));
            exp_q.push_back({3'd0, mk_addr(0, 20 + k), mk_data(0, 20 + k)});
            tick();
            clear_writes();
        end
        chk("t5 ovf when full", 256'(ovf_flag), 256'(0));
        exp_q.push_back({3'd0, mk_addr(0, 25), mk_data(0, 25)});
        compare_head("t5 head");
        set_write(0, mk_addr(0, 25), mk_data(0, 25));
        head_gbus_rdy = 1'b1;
        tick();
        clear_writes();
        chk("t5 ovf after push-pop", 256'(ovf_flag), 256'(0));
        drain("t5 beat", 30);

        // Asynchronous reset with three beats buffered
        head_gbus_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_write(2, mk_addr(2, 30 + k), mk_data(2, 30 + k));
            tick();
            clear_writes();
        end
        tick();
        chk("t6 wen before rst", 256'(head_gbus_wen), 256'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6 wen in rst", 256'(head_gbus_wen), 256'(0));
        chk("t6 busy in rst", 256'(busy), 256'(0));
        chk("t6 src in rst", 256'(head_gbus_src), 256'(0));
`ifdef CORE_GBUS_ARB_PERF_EN
        chk("t6 perf stall rst", 256'(perf_stall_cnt), 256'(0));
        chk("t6 perf beat rst", 256'(perf_beat_cnt), 256'(0));
`endif
        tick();
        tick();
        rst = 1'b0;
        head_gbus_rdy = 1'b1;
        seen = 0;
        repeat (10) begin
            if (head_gbus_wen) seen++;
            tick();
        end
        chk("t6 beats after rst", 256'(seen), 256'(0));
        chk("t6 busy after rst", 256'(busy), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_gbus_arb.md
Name: core_gbus_arb

Overview:
- Head-level collector directly downstream of each core's out_gbus write port (out_gbus_addr/out_gbus_wen/out_gbus_wdata).
- Cores issue fire-and-forget bus writes with no backpressure. This block buffers each core's writes in a small per-core FIFO, arbitrates round-robin, and drives one head-level gbus write channel.
- The head-level channel uses a valid/ready handshake toward the global SRAM / interconnect.

Parameters:
- CORE_NUM, 8, number of cores per head (≤ 16, fits BUS_CORE_ADDR_WIDTH).
- GBUS_DATA_WIDTH, 128, bus data width (MAC_MULT_NUM*IDATA_WIDTH).
- GBUS_ADDR_WIDTH, 19, HEAD_SRAM_BIAS_WIDTH + BUS_CORE_ADDR_WIDTH + BUS_CMEM_ADDR_WIDTH.
- FIFO_DEPTH, 4, entries per core FIFO; power of two, ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- core_gbus_wen  in  CORE_NUM  per-core write strobe; bit i from core i.
- core_gbus_addr  in  CORE_NUM*GBUS_ADDR_WIDTH  packed per-core addresses; core i at [i*W +: W].
- core_gbus_wdata  in  CORE_NUM*GBUS_DATA_WIDTH  packed per-core data.
- head_gbus_wen  out  1  output write valid.
- head_gbus_addr  out  GBUS_ADDR_WIDTH  output address.
- head_gbus_wdata  out  GBUS_DATA_WIDTH  output data.
- head_gbus_src  out  $clog2(CORE_NUM)  index of the core that sourced the current beat.
- head_gbus_rdy  in  1  downstream accepts a beat when head_gbus_wen && head_gbus_rdy.
- ovf_clr  in  1  clears all sticky overflow flags.
- ovf_flag  out  CORE_NUM  sticky per-core overflow (write dropped).
- busy  out  1  high when any FIFO is non-empty or head_gbus_wen is high.

Behaviour:
- Reset values: all FIFOs empty; RR pointer = 0; head_gbus_wen=0, addr=0, wdata=0, src=0; ovf_flag=0; busy=0. Reset mid-operation drops all buffered and in-flight beats without emitting them.
- Push: core_gbus_wen[i] pushes {addr, data} into FIFO i on the rising edge.
- Push to a full FIFO:
  - If FIFO i pops in the same cycle, the push is accepted.
  - Otherwise the write is dropped and ovf_flag[i] is set.
- ovf_flag handling: ovf_clr clears the flags. If a set and ovf_clr occur in the same cycle, the set wins.
- Output register states:
  - EMPTY (head_gbus_wen=0).
  - FULL (head_gbus_wen=1). addr/data/src are held stable while head_gbus_rdy=0.
- Output register load: the register loads when (EMPTY || head_gbus_rdy) and at least one FIFO is non-empty.
  - On load, the FIFO winning arbitration pops in the same cycle.
  - If no FIFO is non-empty and a beat is accepted, head_gbus_wen goes to 0 on the next cycle.
  - Back-to-back beats sustain 1 beat/cycle while rdy=1.
- Arbitration: round-robin among non-empty FIFOs.
  - The search starts at the RR pointer and wraps CORE_NUM-1 → 0.
  - After a grant to core g, the pointer becomes (g+1) mod CORE_NUM.
  - The pointer is unchanged when there is no grant.
- Latency: a write at edge t into an empty FIFO, with the output register EMPTY, yields head_gbus_wen=1 in the cycle after edge t+1 (2 cycles).
- A write in the same cycle as a pop of the same FIFO is not bypassed; it waits its turn in order.
- Ordering: per-core order is preserved; no ordering guarantee across cores.
- Address and data pass through unmodified. The block does not decode the address.
- busy is combinational from FIFO counts and head_gbus_wen.

Optional Feature:
- Macro: CORE_GBUS_ARB_PERF_EN.
- With the macro defined, the block adds:
  - Output perf_stall_cnt [31:0]: counts cycles with head_gbus_wen && !head_gbus_rdy.
  - Output perf_beat_cnt [31:0]: counts accepted beats.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
  - Input perf_clr: synchronously zeroes both counters; perf_clr wins over an increment in the same cycle.
- Without the macro these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - Constants BUS_CMEM_ADDR_WIDTH=13, BUS_CORE_ADDR_WIDTH=4, HEAD_SRAM_BIAS_WIDTH=2.
  - Derived GBUS_ADDR_WIDTH.
  - Typedef gbus_beat_t {addr, data}.
- One sub-module, gbus_arb_fifo: synchronous FIFO with full/empty/count, push-while-full-with-pop allowed. Instantiated CORE_NUM times.
- Arbiter and output register stay in the top module.

Test Plan:
1. Single write: core 3 writes addr 0x00123, data 0xA5.., rdy=1 → exactly one beat two cycles later with src=3 and identical addr/data; busy then drops to 0.
2. All 8 cores write in the same cycle, rdy=1 → 8 consecutive beats with src 0,1,...,7; next simultaneous burst → order 0..7 again (pointer wrapped to 0).
3. Backpressure: rdy=0 for 5 cycles with a beat pending → addr/data/src held stable and head_gbus_wen=1 throughout; rdy=1 → beat accepted and next beat follows the next cycle.
4. Overflow: rdy=0, core 5 writes 5 times with FIFO_DEPTH=4 → 5th write dropped, ovf_flag=8'h20; release rdy → exactly 4 beats from src 5, in order; ovf_clr → flag 0.
5. Full FIFO push with simultaneous pop: core 0 FIFO full, rdy=1, new write → accepted, no overflow, data order preserved.
6. Reset mid-traffic: assert rst with 3 beats buffered → head_gbus_wen=0 immediately (asynchronous); no beats emitted after release. With CORE_GBUS_ARB_PERF_EN: stall and beat counters read 0 after reset and match counted stalls/beats in scenario 3.
